script_serial_sender: RTL and testbench
=======================================

Name: script_serial_sender

Overview:
- Script-mode source that feeds the script side of the script/unscript data mux; produces the dataIn_ready_script / dataIn_bits_script pair.
- On start, walks a byte script held in an external synchronous ROM and serialises each byte as a UART 8N1 frame on dataIn_bits_script, LSB first.
- Inserts a fixed idle gap between frames and pulses done after the last byte; aborts cleanly if script mode is dropped.

Parameters:
- CLKS_PER_BIT, 10416, clock cycles per serial bit (100 MHz / 9600 baud); minimum 2.
- ADDR_W, 8, script ROM address width; maximum script length is 2^ADDR_W bytes.
- GAP_CYCLES, 16, idle-high cycles inserted after each stop bit; 0 means no gap.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- script_mode  in  1  script mode enable, the same signal that drives the mux select.
- start  in  1  single-cycle request to play the script.
- byte_count  in  ADDR_W+1  number of bytes to send; sampled on accepted start.
- rom_addr  out  ADDR_W  script ROM read address.
- rom_data  in  8  ROM read data, valid 1 cycle after rom_addr.
- dataIn_bits_script  out  1  serial line; idle high.
- dataIn_ready_script  out  1  high while a frame is being transmitted (start bit through stop bit).
- busy  out  1  high whenever state is not IDLE.
- done  out  1  single-cycle pulse when the last frame's gap completes.

Behaviour:
- Reset values: dataIn_bits_script=1, dataIn_ready_script=0, busy=0, done=0, rom_addr=0, state=IDLE, all counters 0.
- All outputs are registered.
- States: IDLE, FETCH, LOAD, START, DATA, STOP, GAP.
- IDLE: start accepted only when script_mode=1.
  - On acceptance: latch byte_count, set idx=0 and rom_addr=0.
  - byte_count=0: pulse done next cycle and stay in IDLE.
  - Otherwise go to FETCH.
  - start is ignored while busy=1 or while script_mode=0.
- FETCH: 1 cycle, waiting for ROM latency. Go to LOAD.
- LOAD: capture rom_data into the shift register. Go to START.
- START: line=0 and ready=1 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; ready=1.
- STOP: line=1 and ready=1 for CLKS_PER_BIT cycles. Increment idx.
- GAP: line=1 and ready=0 for GAP_CYCLES cycles (skipped when GAP_CYCLES=0).
  - If idx==byte_count: done=1 for one cycle and return to IDLE.
  - Otherwise rom_addr=idx, go to FETCH.
- Per-byte cost:
  - First line transition (start bit falling) appears 3 cycles after the start cycle: accept, FETCH, LOAD.
  - Frame-to-frame period = 10*CLKS_PER_BIT + GAP_CYCLES + 2 cycles.
- byte_count = 2^ADDR_W: rom_addr wraps to 0 only after the last byte; idx is ADDR_W+1 bits so the compare never aliases.
- script_mode falling in any non-IDLE state:
  - Next cycle: state=IDLE, line=1, ready=0, done not pulsed.
  - A partial frame is truncated. This is accepted: the mux has already switched away.
- start asserted in the same cycle that done pulses: ignored, because busy is still 1 in that cycle.
- rst_n asserted mid-frame: immediate return to reset values, independent of clk.
- Baud counter: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1 and reloads; the bit counter is 3 bits.

Decomposition:
- Shared package `script_pkg`:
  - state enum (IDLE, FETCH, LOAD, START, DATA, STOP, GAP);
  - UART framing constants: DATA_BITS=8, LINE_IDLE=1'b1, START_LEVEL=1'b0.
- One sub-module, `baud_tick_gen`:
  - counts CLKS_PER_BIT, with clear and enable inputs and a tick output;
  - reused by the future unscript-side receiver.
- FSM and shift register stay in the top module.

Test Plan (CLKS_PER_BIT=4, GAP_CYCLES=2, ADDR_W=4):
- Single byte: ROM[0]=8'hA5, byte_count=1, start.
  - Line shows 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, starting 3 cycles after start.
  - ready is high for exactly 40 cycles; done pulses once, 2 cycles after ready falls.
- Three bytes: ROM = 8'h01, 8'hFF, 8'h00, byte_count=3.
  - Frames decode to 01, FF, 00 in order.
  - Start-bit edges are spaced 44 cycles apart; rom_addr sequence is 0,1,2; exactly one done pulse.
- byte_count=0 start: no line activity; done pulses on the next cycle; busy stays 0.
- Abort: drop script_mode in the 5th data bit of frame 2 of 3.
  - Next cycle: line=1, ready=0, busy=0; no done pulse.
  - A later start with script_mode=1 replays from rom_addr=0.
- Ignored requests:
  - start with script_mode=0: no response.
  - second start while busy: no effect on the frame count or the rom_addr sequence.
- Async reset: assert rst_n=0 mid-START bit, between clock edges.
  - Line goes to 1, ready=0, busy=0 before the next clk edge; after release, state is IDLE.

Source files
------------

// File: rtl/script_pkg.sv
// script_pkg
// Shared definitions for the script-mode serial sender and the future
// unscript-side receiver: FSM state encoding and UART 8N1 framing constants.
package script_pkg;

  // Sender FSM states, in the order a frame walks through them.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5,
    GAP   = 3'd6
  } state_e;

  // UART framing: 8 data bits, line idles high, start bit is low.
  localparam int   DATA_BITS   = 8;
  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen
// Free-running bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled and
// raises tick during the last cycle of each bit period, then reloads to 0.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   clear      - force the count back to 0 (takes priority over enable)
//   enable     - advance the count
//   tick       - high in the final cycle of a bit period
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign tick = enable && !clear && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/script_serial_sender.sv
// script_serial_sender
// Plays a byte script out of an external synchronous ROM as UART 8N1 frames
// on the script side of the script/unscript data mux.
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset
//   script_mode         - script mode enable (same as the mux select)
//   start               - one-cycle request to play the script
//   byte_count          - number of bytes to play, latched on accepted start
//   rom_addr / rom_data - ROM read port, data valid one cycle after address
//   dataIn_bits_script  - serial line, idles high
//   dataIn_ready_script - high from start bit through stop bit
//   busy                - sender is working through a script
//   done                - one-cycle pulse after the last frame's gap
module script_serial_sender #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int ADDR_W       = 8,
  parameter int GAP_CYCLES   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              script_mode,
  input  logic              start,
  input  logic [ADDR_W:0]   byte_count,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              dataIn_bits_script,
  output logic              dataIn_ready_script,
  output logic              busy,
  output logic              done
);

  import script_pkg::*;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_e                state_q, state_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic [ADDR_W:0]       idx_q, idx_d;
  logic [ADDR_W-1:0]     rom_addr_q, rom_addr_d;
  logic [DATA_BITS-1:0]  shreg_q, shreg_d;
  logic [2:0]            bit_q, bit_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  line_q, line_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  baud_en;
  logic                  baud_tick;
  logic                  frame_end;
  logic                  hold_busy;
  logic [ADDR_W:0]       end_idx;
  logic [ADDR_W:0]       idx_inc;

  // The bit timer only runs while a frame is on the line, so every frame
  // starts its start bit with a fresh count.
  assign baud_en = (state_q == START) || (state_q == DATA) || (state_q == STOP);
  assign idx_inc = idx_q + (ADDR_W+1)'(1);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!baud_en),
    .enable(baud_en),
    .tick  (baud_tick)
  );

  // Next-state logic. frame_end marks the point where a frame and its gap
  // are fully over and the script either finishes or fetches the next byte.
  // busy is held for the done cycle so a start coinciding with done is
  // ignored; dropping script_mode overrides everything and returns to IDLE.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    rom_addr_d = rom_addr_q;
    shreg_d    = shreg_q;
    bit_d      = bit_q;
    gap_d      = gap_q;
    line_d     = line_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    frame_end  = 1'b0;
    hold_busy  = 1'b0;
    end_idx    = idx_q;

    case (state_q)
      IDLE: begin
        if (start && script_mode && !busy_q) begin
          count_d    = byte_count;
          idx_d      = '0;
          rom_addr_d = '0;
          if (byte_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        shreg_d = rom_data;
        state_d = START;
        line_d  = START_LEVEL;
        ready_d = 1'b1;
      end
      START: begin
        if (baud_tick) begin
          state_d = DATA;
          bit_d   = '0;
          line_d  = shreg_q[0];
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
            line_d  = LINE_IDLE;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = shreg_q >> 1;
            line_d  = shreg_q[1];
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          idx_d   = idx_inc;
          ready_d = 1'b0;
          line_d  = LINE_IDLE;
          if (GAP_CYCLES == 0) begin
            frame_end = 1'b1;
            end_idx   = idx_inc;
          end else begin
            state_d = GAP;
            gap_d   = '0;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d     = '0;
          frame_end = 1'b1;
          end_idx   = idx_q;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (frame_end) begin
      rom_addr_d = end_idx[ADDR_W-1:0];
      if (end_idx == count_q) begin
        state_d   = IDLE;
        done_d    = 1'b1;
        hold_busy = 1'b1;
      end else begin
        state_d = FETCH;
      end
    end

    if ((state_q != IDLE) && !script_mode) begin
      state_d   = IDLE;
      line_d    = LINE_IDLE;
      ready_d   = 1'b0;
      done_d    = 1'b0;
      hold_busy = 1'b0;
    end

    busy_d = (state_d != IDLE) || hold_busy;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      idx_q      <= '0;
      rom_addr_q <= '0;
      shreg_q    <= '0;
      bit_q      <= '0;
      gap_q      <= '0;
      line_q     <= LINE_IDLE;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      rom_addr_q <= rom_addr_d;
      shreg_q    <= shreg_d;
      bit_q      <= bit_d;
      gap_q      <= gap_d;
      line_q     <= line_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rom_addr            = rom_addr_q;
  assign dataIn_bits_script  = line_q;
  assign dataIn_ready_script = ready_q;
  assign busy                = busy_q;
  assign done                = done_q;

endmodule

// File: tb/tb_script_serial_sender.sv
// tb_script_serial_sender
// Directed bench for script_serial_sender with CLKS_PER_BIT=4, GAP_CYCLES=2,
// ADDR_W=4. A table of scripts is played and every output is compared cycle
// by cycle against waveforms built from the frame timing; abort, ignored
// requests and asynchronous reset are covered by hand-written sequences.
module tb_script_serial_sender;

  localparam int CPB    = 4;
  localparam int GAP    = 2;
  localparam int AW     = 4;
  localparam int PERIOD = 10 * CPB + GAP + 2;
  localparam int MAXC   = 200;

  typedef struct {
    int              count;
    logic [2:0][7:0] bytes;
    int              extra_start;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          script_mode;
  logic          start;
  logic [AW:0]   byte_count;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic          line;
  logic          ready;
  logic          busy;
  logic          done;

  logic [7:0]    rom_mem [0:15];

  logic          cap_line  [0:MAXC];
  logic          cap_ready [0:MAXC];
  logic          cap_busy  [0:MAXC];
  logic          cap_done  [0:MAXC];
  logic [AW-1:0] cap_addr  [0:MAXC];

  int            n_vec;
  int            n_miss;
  vec_t          vecs [5];

  script_serial_sender #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (AW),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .script_mode        (script_mode),
    .start              (start),
    .byte_count         (byte_count),
    .rom_addr           (rom_addr),
    .rom_data           (rom_data),
    .dataIn_bits_script (line),
    .dataIn_ready_script(ready),
    .busy               (busy),
    .done               (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous script ROM: data follows the address by one clock.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  // Load the script, pulse start and record every output for the whole run.
  task automatic apply_stimulus(input vec_t v, output int len);
    for (int k = 0; k < 3; k++) rom_mem[k] = v.bytes[k];
    len = PERIOD * v.count + 8;
    @(negedge clk);
    script_mode = 1'b1;
    byte_count  = (AW+1)'(v.count);
    start       = 1'b1;
    for (int n = 1; n <= len; n++) begin
      @(negedge clk);
      cap_line[n]  = line;
      cap_ready[n] = ready;
      cap_busy[n]  = busy;
      cap_done[n]  = done;
      cap_addr[n]  = rom_addr;
      start = (n == v.extra_start);
    end
    start = 1'b0;
  endtask

  // Compare captured waveforms with the ideal frame timing: frame k starts
  // its start bit 3 + 44k cycles after start, done lands 44*count + 1.
  task automatic check_vector(input vec_t v, input int vi, input int len);
    int bad_line, bad_ready, bad_busy, bad_done;
    int f_line, f_ready, f_busy, f_done;
    logic el, er, eb, ed;
    int f, b;
    bad_line = 0; bad_ready = 0; bad_busy = 0; bad_done = 0;
    f_line = -1; f_ready = -1; f_busy = -1; f_done = -1;
    for (int n = 1; n <= len; n++) begin
      el = 1'b1;
      er = 1'b0;
      for (int k = 0; k < v.count; k++) begin
        f = 3 + PERIOD * k;
        if (n >= f && n < f + 10 * CPB) begin
          b  = (n - f) / CPB;
          er = 1'b1;
          if (b == 0) el = 1'b0;
          else if (b == 9) el = 1'b1;
          else el = v.bytes[k][b-1];
        end
      end
      ed = (n == PERIOD * v.count + 1);
      eb = (v.count > 0) && (n <= PERIOD * v.count + 1);
      if (cap_line[n] !== el) begin bad_line++; if (f_line < 0) f_line = n; end
      if (cap_ready[n] !== er) begin bad_ready++; if (f_ready < 0) f_ready = n; end
      if (cap_busy[n] !== eb) begin bad_busy++; if (f_busy < 0) f_busy = n; end
      if (cap_done[n] !== ed) begin bad_done++; if (f_done < 0) f_done = n; end
    end
    check_output($sformatf("v%0d line_wave bad samples (first n=%0d)", vi, f_line), bad_line, 0);
    check_output($sformatf("v%0d ready_wave bad samples (first n=%0d)", vi, f_ready), bad_ready, 0);
    check_output($sformatf("v%0d busy_wave bad samples (first n=%0d)", vi, f_busy), bad_busy, 0);
    check_output($sformatf("v%0d done_wave bad samples (first n=%0d)", vi, f_done), bad_done, 0);
    check_output($sformatf("v%0d rom_addr after accept", vi), cap_addr[1], 0);
    for (int k = 0; k < v.count; k++) begin
      check_output($sformatf("v%0d rom_addr frame %0d", vi, k), cap_addr[3 + PERIOD * k], k);
    end
  endtask

  initial begin
    int len;
    int bad;
    n_vec  = 0;
    n_miss = 0;
    rst_n       = 1'b0;
    script_mode = 1'b0;
    start       = 1'b0;
    byte_count  = '0;
    for (int i = 0; i < 16; i++) rom_mem[i] = 8'h00;

    vecs[0] = '{count: 1, bytes: {8'h00, 8'h00, 8'hA5}, extra_start: 0};
    vecs[1] = '{count: 3, bytes: {8'h00, 8'hFF, 8'h01}, extra_start: 0};
    vecs[2] = '{count: 0, bytes: {8'h00, 8'h00, 8'h00}, extra_start: 0};
    vecs[3] = '{count: 2, bytes: {8'h00, 8'h81, 8'h3C}, extra_start: 10};
    vecs[4] = '{count: 1, bytes: {8'h00, 8'h00, 8'h5A}, extra_start: PERIOD + 1};

    // Reset values.
    repeat (3) @(negedge clk);
    check_output("reset line", line, 1);
    check_output("reset ready", ready, 0);
    check_output("reset busy", busy, 0);
    check_output("reset done", done, 0);
    check_output("reset rom_addr", rom_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of scripts, including a start while busy and one on the done cycle.
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(vecs[i], len);
      check_vector(vecs[i], i, len);
    end

    // start with script_mode low is ignored.
    @(negedge clk);
    script_mode = 1'b0;
    byte_count  = 5'd1;
    start       = 1'b1;
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy !== 1'b0 || line !== 1'b1 || done !== 1'b0 || ready !== 1'b0) bad++;
    end
    check_output("no response without script_mode", bad, 0);

    // Abort: drop script_mode in the 5th data bit of frame 2 of 3.
    rom_mem[0] = 8'h01; rom_mem[1] = 8'hFF; rom_mem[2] = 8'h00;
    @(negedge clk);
    script_mode = 1'b1;
    byte_count  = 5'd3;
    start       = 1'b1;
    for (int n = 1; n <= 67; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check_output("abort pre ready", ready, 1);
    @(negedge clk);
    script_mode = 1'b0;
    @(negedge clk);
    check_output("abort line", line, 1);
    check_output("abort ready", ready, 0);
    check_output("abort busy", busy, 0);
    check_output("abort done", done, 0);
    bad = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done !== 1'b0 || line !== 1'b1 || busy !== 1'b0) bad++;
    end
    check_output("abort quiet afterwards", bad, 0);
    apply_stimulus('{count: 1, bytes: {8'h00, 8'hFF, 8'h01}, extra_start: 0}, len);
    check_vector('{count: 1, bytes: {8'h00, 8'hFF, 8'h01}, extra_start: 0}, 5, len);

    // Asynchronous reset in the middle of a start bit, between clock edges.
    rom_mem[0] = 8'hC3;
    @(negedge clk);
    script_mode = 1'b1;
    byte_count  = 5'd1;
    start       = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check_output("areset pre line", line, 0);
    #2 rst_n = 1'b0;
    #1;
    check_output("areset line", line, 1);
    check_output("areset ready", ready, 0);
    check_output("areset busy", busy, 0);
    check_output("areset done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("areset idle busy", busy, 0);
    check_output("areset idle line", line, 1);
    apply_stimulus(vecs[0], len);
    check_vector(vecs[0], 6, len);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
